sync_fifo_thresh: RTL

Parametrised synchronous FIFO and successor to the existing single-clock FIFO. Adds an asynchronous active-low reset, simultaneous read+write in one cycle, full use of all 2**p_ADDRESS_WIDTH entries, and an occupancy count output. Also adds programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. Used as the general buffering element between streaming blocks in one clock domain.

---
 rtl/sync_fifo_thresh.sv | 64 ++++++
 1 files changed

// File: rtl/sync_fifo_thresh.sv
// sync_fifo_thresh: single-clock FIFO with occupancy count, almost-full/empty thresholds, flush and sticky error flags
module sync_fifo_thresh #(
  parameter int p_ADDRESS_WIDTH = 2,
  parameter int p_DATA_WIDTH    = 8,
  parameter int p_ALMOST_FULL   = 3,
  parameter int p_ALMOST_EMPTY  = 1
) (
  input  logic                     i_CLK,
  input  logic                     i_RESET_N,
  input  logic                     i_FLUSH,
  input  logic                     i_WRITE_REQUEST,
  input  logic                     i_READ_REQUEST,
  input  logic [p_DATA_WIDTH-1:0]  i_INPUT,
  output logic [p_DATA_WIDTH-1:0]  o_OUTPUT,
  output logic                     o_VALID,
  output logic                     o_FIFO_EMPTY,
  output logic                     o_FIFO_FULL,
  output logic                     o_ALMOST_EMPTY,
  output logic                     o_ALMOST_FULL,
  output logic [p_ADDRESS_WIDTH:0] o_COUNT,
  output logic                     o_OVERFLOW,
  output logic                     o_UNDERFLOW
);
  localparam int D  = 1 << p_ADDRESS_WIDTH;
  localparam int CW = p_ADDRESS_WIDTH + 1;
  logic [p_DATA_WIDTH-1:0]    mem [D];
  logic [p_ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                       wr_ok, rd_ok;
  logic [CW-1:0]              cnt_n;
  always_comb begin
    wr_ok = i_WRITE_REQUEST & (~o_FIFO_FULL | i_READ_REQUEST);
    rd_ok = i_READ_REQUEST & ~o_FIFO_EMPTY;
    cnt_n = i_FLUSH ? '0 : o_COUNT + CW'(wr_ok) - CW'(rd_ok);
  end
  always_ff @(posedge i_CLK)
    if (wr_ok && !i_FLUSH) mem[wr_ptr] <= i_INPUT;
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_COUNT        <= '0;
      o_OUTPUT       <= '0;
      o_VALID        <= 1'b0;
      o_FIFO_EMPTY   <= 1'b1;
      o_FIFO_FULL    <= 1'b0;
      o_ALMOST_EMPTY <= 1'b1;
      o_ALMOST_FULL  <= (p_ALMOST_FULL == 0);
      o_OVERFLOW     <= 1'b0;
      o_UNDERFLOW    <= 1'b0;
    end else begin
      wr_ptr         <= i_FLUSH ? '0 : wr_ptr + p_ADDRESS_WIDTH'(wr_ok);
      rd_ptr         <= i_FLUSH ? '0 : rd_ptr + p_ADDRESS_WIDTH'(rd_ok);
      o_COUNT        <= cnt_n;
      o_OUTPUT       <= (rd_ok && !i_FLUSH) ? mem[rd_ptr] : o_OUTPUT;
      o_VALID        <= rd_ok & ~i_FLUSH;
      o_FIFO_EMPTY   <= cnt_n == '0;
      o_FIFO_FULL    <= cnt_n == CW'(D);
      o_ALMOST_EMPTY <= cnt_n <= CW'(p_ALMOST_EMPTY);
      o_ALMOST_FULL  <= cnt_n >= CW'(p_ALMOST_FULL);
      o_OVERFLOW     <= ~i_FLUSH & (o_OVERFLOW | (i_WRITE_REQUEST & ~wr_ok));
      o_UNDERFLOW    <= ~i_FLUSH & (o_UNDERFLOW | (i_READ_REQUEST & ~rd_ok));
    end
  end
endmodule
